// File: rtl/qspis_clkdet_if.sv
// Pad-side SPI bus between an external QSPI master and the target clock detector.
interface qspis_clkdet_if;
  logic sck_in;
  logic ssn_in;
  logic mosi_in;
  logic miso_out;
  logic miso_oe;

  modport master (output sck_in, ssn_in, mosi_in, input miso_out, miso_oe);
  modport slave  (input sck_in, ssn_in, mosi_in, output miso_out, miso_oe);
endinterface

// File: rtl/qspis_clkdet.sv
// QSPI target clock detector: oversamples SCK/SSN/MOSI, pulses on SCK edges, shifts bytes in/out.
// Optional SCK period measurement enabled by defining QSPIS_SCK_MEAS_EN.
module qspis_clkdet #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int PERIOD_W    = 6
) (
  input  logic                clk,
  input  logic                rstn,
  qspis_clkdet_if.slave       spi,
  output logic                o_cs_active,
  output logic                o_spi_rise,
  output logic                o_spi_fall,
  output logic [DATA_W-1:0]   o_rx_data,
  output logic                o_rx_valid,
  input  logic [DATA_W-1:0]   i_tx_data,
  output logic                o_tx_req,
  output logic [PERIOD_W-1:0] o_meas_period,
  output logic                o_meas_valid
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_hist;
  logic                   r_cs;
  logic                   r_rise;
  logic                   r_fall;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-2:0]      r_rx_shift;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic [DATA_W-1:0]      r_tx_shift;
  logic                   r_tx_req;

  logic w_sck;
  logic w_ssn;
  logic w_mosi;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_ssn  = r_ssn_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_sync  <= '1;
      r_ssn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b1;
      r_cs        <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.sck_in};
      r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], spi.ssn_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi_in};
      r_sck_hist  <= w_sck;
      r_cs        <= ~w_ssn;
      r_rise      <= r_cs & w_sck & ~r_sck_hist;
      r_fall      <= r_cs & ~w_sck & r_sck_hist;
    end
  end

  // A pulse registered just as cs drops is swallowed by the idle clear below.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_shift <= '0;
      r_tx_req   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (!r_cs) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (r_rise) begin
        r_rx_shift <= {r_rx_shift[DATA_W-3:0], w_mosi};
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= {r_rx_shift, w_mosi};
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (r_fall) begin
        if (r_bit_cnt == '0) begin
          r_tx_shift <= i_tx_data;
          r_tx_req   <= 1'b1;
        end else begin
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi.miso_out = r_tx_shift[DATA_W-1];
  assign spi.miso_oe  = r_cs;
  assign o_cs_active  = r_cs;
  assign o_spi_rise   = r_rise;
  assign o_spi_fall   = r_fall;
  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_tx_req     = r_tx_req;

`ifdef QSPIS_SCK_MEAS_EN
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [PERIOD_W-1:0] r_meas_period;
  logic                r_meas_valid;
  logic                r_fall_seen;
  logic [PERIOD_W-1:0] w_per_inc;

  assign w_per_inc = (&r_per_cnt) ? r_per_cnt : r_per_cnt + 1'b1;

  // The first fall in a cs window only arms the measurement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_per_cnt     <= '0;
      r_meas_period <= '0;
      r_meas_valid  <= 1'b0;
      r_fall_seen   <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!r_cs) begin
        r_per_cnt   <= '0;
        r_fall_seen <= 1'b0;
      end else if (r_fall) begin
        r_per_cnt   <= '0;
        r_fall_seen <= 1'b1;
        if (r_fall_seen) begin
          r_meas_period <= w_per_inc;
          r_meas_valid  <= 1'b1;
        end
      end else begin
        r_per_cnt <= w_per_inc;
      end
    end
  end

  assign o_meas_period = r_meas_period;
  assign o_meas_valid  = r_meas_valid;
`else
  assign o_meas_period = '0;
  assign o_meas_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_qspis_clkdet.sv
// Bench for qspis_clkdet: bit-banged SPI master, rx scoreboard, pulse counters.
`timescale 1ns/1ps
module tb_qspis_clkdet;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cs_active, spi_rise, spi_fall, rx_valid, tx_req, meas_valid;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] tx_data = '0;
  logic [PW-1:0] meas_period;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rise = 0, n_fall = 0, n_txreq = 0, n_measv = 0;

  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] obs_rx[$];
  int            obs_rx_t[$];
  logic [PW-1:0] obs_meas[$];

  always #5 clk = ~clk;

  qspis_clkdet_if spi ();

  qspis_clkdet #(.SYNC_STAGES(2), .DATA_W(DW), .PERIOD_W(PW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi           (spi.slave),
    .o_cs_active   (cs_active),
    .o_spi_rise    (spi_rise),
    .o_spi_fall    (spi_fall),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_tx_data     (tx_data),
    .o_tx_req      (tx_req),
    .o_meas_period (meas_period),
    .o_meas_valid  (meas_valid)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_rise)   n_rise  <= n_rise + 1;
    if (spi_fall)   n_fall  <= n_fall + 1;
    if (tx_req)     n_txreq <= n_txreq + 1;
    if (meas_valid) begin
      n_measv <= n_measv + 1;
      obs_meas.push_back(meas_period);
    end
    if (rx_valid) begin
      obs_rx.push_back(rx_data);
      obs_rx_t.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_bit(input logic mo, input int half, output logic mi);
    spi.sck_in  = 1'b0;
    spi.mosi_in = mo;
    tick(half);
    mi = spi.miso_out;
    spi.sck_in = 1'b1;
    tick(half);
  endtask

  task automatic send_byte(input logic [DW-1:0] mo, output logic [DW-1:0] mi);
    logic b;
    exp_rx.push_back(mo);
    for (int i = DW - 1; i >= 0; i--) begin
      sck_bit(mo[i], 4, b);
      mi[i] = b;
    end
  endtask

  task automatic cs_begin();
    spi.ssn_in = 1'b0;
    tick(6);
  endtask

  task automatic cs_end();
    tick(4);
    spi.ssn_in = 1'b1;
    tick(8);
  endtask

  task automatic check_rx(input string name);
    logic [DW-1:0] e, o;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (obs_rx.size() == 0) begin
        failures++;
        $display("FAIL %s_rx: no rx_valid, expected rx_data=%02h", name, e);
      end else begin
        o = obs_rx.pop_front();
        void'(obs_rx_t.pop_front());
        if (o !== e) begin
          failures++;
          $display("FAIL %s_rx: rx_data=%02h expected %02h", name, o, e);
        end
      end
    end
    checks++;
    if (obs_rx.size() != 0) begin
      failures++;
      $display("FAIL %s_extra_rx: %0d unexpected rx_valid pulses, expected 0", name, obs_rx.size());
    end
    obs_rx.delete();
    obs_rx_t.delete();
  endtask

  task automatic test_reset();
    int r0, f0;
    spi.sck_in = 1'b1; spi.ssn_in = 1'b1; spi.mosi_in = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spi.sck_in = ~spi.sck_in;
      tick(2);
    end
    checks++;
    if ({cs_active, spi_rise, spi_fall, rx_valid, tx_req, meas_valid, rx_data, meas_period,
         spi.miso_out, spi.miso_oe} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cs=%b rise=%b fall=%b rxv=%b txreq=%b mv=%b rx=%02h mp=%0d miso=%b oe=%b, expected all 0",
               cs_active, spi_rise, spi_fall, rx_valid, tx_req, meas_valid, rx_data, meas_period,
               spi.miso_out, spi.miso_oe);
    end
    rstn = 1'b1;
    r0 = n_rise; f0 = n_fall;
    for (int i = 0; i < 20; i++) begin
      spi.sck_in = ~spi.sck_in;
      tick(2);
    end
    spi.sck_in = 1'b1;
    tick(4);
    checks++;
    if ((n_rise - r0) != 0 || (n_fall - f0) != 0 || cs_active !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_pulses: rise=%0d fall=%0d cs=%b, expected 0 0 0", n_rise - r0, n_fall - f0, cs_active);
    end
  endtask

  task automatic test_receive();
    int r0, f0;
    logic [DW-1:0] mi;
    r0 = n_rise; f0 = n_fall;
    cs_begin();
    checks++;
    if (cs_active !== 1'b1 || spi.miso_oe !== 1'b1) begin
      failures++;
      $display("FAIL cs_active: cs=%b oe=%b, expected 1 1", cs_active, spi.miso_oe);
    end
    send_byte(8'hA5, mi);
    cs_end();
    checks++;
    if ((n_rise - r0) != 8 || (n_fall - f0) != 8) begin
      failures++;
      $display("FAIL receive_pulses: rise=%0d fall=%0d, expected 8 8", n_rise - r0, n_fall - f0);
    end
    check_rx("receive");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] mi;
    cs_begin();
    send_byte(8'h3C, mi);
    send_byte(8'hC3, mi);
    cs_end();
    checks++;
    if (obs_rx_t.size() < 2 || (obs_rx_t[1] - obs_rx_t[0]) != 64) begin
      failures++;
      $display("FAIL b2b_spacing: %0d pulses, spacing=%0d, expected 2 pulses 64 apart",
               obs_rx_t.size(), (obs_rx_t.size() < 2) ? -1 : obs_rx_t[1] - obs_rx_t[0]);
    end
    check_rx("b2b");
  endtask

  task automatic test_transmit();
    logic [DW-1:0] mi;
    int q0;
    tx_data = 8'h96;
    cs_begin();
    q0 = n_txreq;
    send_byte(8'h11, mi);
    checks++;
    if (mi !== 8'h96 || (n_txreq - q0) != 1) begin
      failures++;
      $display("FAIL tx_byte0: miso=%02h tx_req=%0d, expected 96 1", mi, n_txreq - q0);
    end
    tx_data = 8'h5A;
    q0 = n_txreq;
    send_byte(8'h22, mi);
    checks++;
    if (mi !== 8'h5A || (n_txreq - q0) != 1) begin
      failures++;
      $display("FAIL tx_byte1: miso=%02h tx_req=%0d, expected 5a 1", mi, n_txreq - q0);
    end
    cs_end();
    check_rx("transmit");
  endtask

  task automatic test_abort();
    logic b;
    logic [DW-1:0] mi;
    logic [4:0] part;
    part = 5'b10110;
    cs_begin();
    for (int i = 4; i >= 0; i--) sck_bit(part[i], 4, b);
    cs_end();
    checks++;
    if (dut.r_bit_cnt !== '0) begin
      failures++;
      $display("FAIL abort_bitcnt: bit_cnt=%0d expected 0", dut.r_bit_cnt);
    end
    check_rx("abort");
    cs_begin();
    send_byte(8'h81, mi);
    cs_end();
    check_rx("after_abort");
    checks++;
    if (rx_data !== 8'h81) begin
      failures++;
      $display("FAIL after_abort_data: rx_data=%02h expected 81", rx_data);
    end
  endtask

  task automatic test_reset_midbyte();
    logic b;
    tx_data = 8'hFF;
    cs_begin();
    for (int i = 0; i < 3; i++) sck_bit(1'b1, 4, b);
    spi.sck_in = 1'b0;
    tick(5);
    checks++;
    if (spi.miso_out !== 1'b1 || cs_active !== 1'b1) begin
      failures++;
      $display("FAIL midbyte_active: miso=%b cs=%b, expected 1 1", spi.miso_out, cs_active);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({cs_active, spi_rise, spi_fall, rx_valid, tx_req, meas_valid, rx_data, meas_period,
         spi.miso_out, spi.miso_oe} !== '0) begin
      failures++;
      $display("FAIL midbyte_reset: cs=%b rise=%b fall=%b rxv=%b txreq=%b mv=%b rx=%02h mp=%0d miso=%b oe=%b, expected all 0",
               cs_active, spi_rise, spi_fall, rx_valid, tx_req, meas_valid, rx_data, meas_period,
               spi.miso_out, spi.miso_oe);
    end
    tick(2);
    spi.ssn_in = 1'b1;
    spi.sck_in = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(6);
    exp_rx.delete();
    check_rx("midbyte");
  endtask

  task automatic test_meas();
    logic [DW-1:0] mi;
    logic b;
    int m0;
    obs_meas.delete();
    m0 = n_measv;
    cs_begin();
    send_byte(8'h5A, mi);
    cs_end();
    check_rx("meas");
`ifdef QSPIS_SCK_MEAS_EN
    checks++;
    if (obs_meas.size() != 7 || obs_meas[0] !== 6'd8) begin
      failures++;
      $display("FAIL meas_p8: %0d pulses first=%0d, expected 7 pulses first=8",
               obs_meas.size(), (obs_meas.size() == 0) ? -1 : int'(obs_meas[0]));
    end
    obs_meas.delete();
    cs_begin();
    sck_bit(1'b1, 40, b);
    sck_bit(1'b0, 40, b);
    cs_end();
    checks++;
    if (obs_meas.size() != 1 || obs_meas[0] !== 6'd63) begin
      failures++;
      $display("FAIL meas_sat: %0d pulses first=%0d, expected 1 pulse value 63",
               obs_meas.size(), (obs_meas.size() == 0) ? -1 : int'(obs_meas[0]));
    end
`else
    checks++;
    if ((n_measv - m0) != 0 || meas_period !== '0) begin
      failures++;
      $display("FAIL meas_disabled: meas_valid pulses=%0d meas_period=%0d, expected 0 0",
               n_measv - m0, meas_period);
    end
`endif
    check_rx("meas_end");
  endtask

  initial begin
    spi.sck_in  = 1'b1;
    spi.ssn_in  = 1'b1;
    spi.mosi_in = 1'b0;
    tick(2);
    test_reset();
    test_receive();
    test_back_to_back();
    test_transmit();
    test_abort();
    test_reset_midbyte();
    test_meas();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspis_clkdet.md
Name: qspis_clkdet

Overview:
- Target-side (slave) counterpart of the QSPI master clock generator.
- Oversamples an external SCK/SSN/MOSI with the local clk and produces single-cycle spi_rise/spi_fall pulses.
- Assembles received bytes (sampled on SCK rise) and shifts transmit bytes onto MISO (driven on SCK fall).
- SCK idles high, matching the master's idle level; sits between the pads and the target command/data FSM.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck_in/ssn_in/mosi_in (min 2)
- DATA_W, 8, shift/byte width
- PERIOD_W, 6, width of measured SCK period (optional feature)

Ports:
- clk  input  1  local clock; must be >= 2*(SYNC_STAGES+2) x SCK frequency
- rstn  input  1  asynchronous, active-low reset
- sck_in  input  1  external SCK pin, idles high
- ssn_in  input  1  external chip-select, active low
- mosi_in  input  1  serial data from master
- miso_out  output  1  serial data to master
- miso_oe  output  1  MISO output enable
- cs_active  output  1  synchronized chip-select, active high
- spi_rise  output  1  one-clk pulse per detected SCK rising edge
- spi_fall  output  1  one-clk pulse per detected SCK falling edge
- rx_data  output  DATA_W  last complete received byte, MSB first
- rx_valid  output  1  one-clk pulse when rx_data updates
- tx_data  input  DATA_W  next byte to transmit
- tx_req  output  1  one-clk pulse: tx_data consumed; next byte needed before next byte boundary
- meas_period  output  PERIOD_W  measured SCK period in clk cycles
- meas_valid  output  1  one-clk pulse when meas_period updates

Behaviour:
- Reset values:
  - sck sync chain 1; ssn sync chain 1; mosi sync chain 0.
  - All outputs 0; bit_cnt 0; shift registers 0.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops; sck has one further history flop.
  - spi_rise = registered (cs_active & sck_sync & !sck_hist); spi_fall likewise with polarities swapped.
  - Pulse latency: SYNC_STAGES+1 clk edges after the pin edge is first sampled.
- cs_active: registered !ssn_sync; miso_oe = cs_active.
- While cs_active=0: no rise/fall pulses, bit_cnt=0, rx shift cleared. Partial bytes are discarded with no rx_valid.
- Receive, on spi_rise:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++ (wraps at DATA_W).
  - When bit_cnt==DATA_W-1: rx_data <= {rx_shift[DATA_W-2:0], mosi_sync} and rx_valid=1 in the same cycle rx_data changes.
- Transmit, on spi_fall:
  - If bit_cnt==0 (first fall of a byte): tx_shift <= tx_data, tx_req pulse same cycle.
  - Otherwise tx_shift <<= 1.
  - miso_out = tx_shift[DATA_W-1], registered.
- Before the first fall of a transaction, miso_out holds its previous value (0 after reset).
- ssn deassert mid-byte: bit_cnt cleared on the cycle cs_active falls; tx_shift retained; no tx_req.
- Simultaneous spi_rise and spi_fall cannot occur (single sck history).
- rstn asserted mid-operation returns every register to its reset value immediately.
- Timing requirement: SCK half period must be >= SYNC_STAGES+2 clk cycles so MISO is stable before the master samples. Shorter periods are unsupported and not checked.

Optional Feature:
- Macro: QSPIS_SCK_MEAS_EN.
- Defined:
  - PERIOD_W counter increments every clk while cs_active and clears on spi_fall.
  - On each spi_fall after the first in a cs window: meas_period <= counter+1 and meas_valid pulses.
  - Counter saturates at all-ones, so meas_period = 2^PERIOD_W-1 on overflow.
  - Counter clears when cs_active=0.
- Not defined: meas_period and meas_valid tied 0; no counter logic.

Test Plan:
- Reset: hold rstn=0 with sck_in toggling -> all outputs 0. Release with ssn high, sck toggling 20 cycles -> no spi_rise/spi_fall.
- Receive: SYNC_STAGES=2, SCK period 8 clk, ssn low, master sends 0xA5 -> exactly 8 spi_rise and 8 spi_fall pulses; one rx_valid with rx_data=0xA5.
- Back-to-back receive: 0x3C then 0xC3 without ssn gap -> two rx_valid pulses 64 clk apart, values 0x3C then 0xC3.
- Transmit: tx_data=0x96, then 0x5A after tx_req -> master samples 1,0,0,1,0,1,1,0 then 0,1,0,1,1,0,1,0; tx_req at each byte's first fall.
- Abort: ssn high after 5 bits -> no rx_valid, bit_cnt 0. Next transaction 0x81 -> rx_data=0x81. Separately, rstn pulse mid-byte -> all outputs back to 0.
- QSPIS_SCK_MEAS_EN: period 8 -> meas_valid on second fall with meas_period=8. Period 80 with PERIOD_W=6 -> meas_period=63. Macro undefined -> meas_valid never asserts.
